// File: rtl/button_conditioner.sv
// Synchronize, debounce and edge-detect the four active-low player buttons.
// Optional hold-to-repeat move pulses are built when BTN_AUTOREPEAT_EN is defined.
//
// Ports:
//   clk           - system clock, all state on the rising edge
//   reset         - synchronous, active-low
//   btn_n[3:0]    - raw asynchronous buttons, 0 = pressed
//                   (0 p1l/p1u, 1 p1r/p1d, 2 p2l/p2u, 3 p2r/p2d)
//   btn_level_n   - debounced stable level, 0 = pressed
//   press_pulse   - one cycle on stable released->pressed
//   release_pulse - one cycle on stable pressed->released
//   move_pulse    - one cycle on press and, with BTN_AUTOREPEAT_EN, on each repeat
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 15000000,
    parameter int unsigned REPEAT_PERIOD   = 2500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn_n,
    output logic [3:0] btn_level_n,
    output logic [3:0] press_pulse,
    output logic [3:0] release_pulse,
    output logic [3:0] move_pulse
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [3:0]    s1;
    logic [3:0]    s2;
    logic [3:0]    stable;
    logic [DW-1:0] cnt [4];
    logic [3:0]    flip;
    logic [3:0]    fire;

    // flip: the synchronized input has disagreed long enough; stable
    // takes the value of s2 at this edge.
    always_comb begin
        flip = '0;
        for (int i = 0; i < 4; i++) begin
            flip[i] = (s2[i] != stable[i]) &&
                      (cnt[i] == DW'(DEBOUNCE_CYCLES - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1            <= '1;
            s2            <= '1;
            stable        <= '1;
            press_pulse   <= '0;
            release_pulse <= '0;
            move_pulse    <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1 <= btn_n;
            s2 <= s1;
            for (int i = 0; i < 4; i++) begin
                if (s2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (flip[i]) begin
                    stable[i] <= s2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
            press_pulse   <= flip & ~s2;
            release_pulse <= flip & s2;
            move_pulse    <= (flip & ~s2) | fire;
        end
    end

    assign btn_level_n = stable;

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                                   REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = $clog2(RMAX + 1);

    logic [RW-1:0] rcnt [4];

    // A release landing on the expiry edge suppresses the repeat.
    always_comb begin
        fire = '0;
        for (int i = 0; i < 4; i++) begin
            fire[i] = !stable[i] && (rcnt[i] == RW'(1)) &&
                      !(flip[i] && s2[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                rcnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (flip[i] && !s2[i]) begin
                    rcnt[i] <= RW'(REPEAT_DELAY);
                end else if (stable[i] || flip[i]) begin
                    rcnt[i] <= '0;
                end else if (fire[i]) begin
                    rcnt[i] <= RW'(REPEAT_PERIOD);
                end else begin
                    rcnt[i] <= rcnt[i] - 1'b1;
                end
            end
        end
    end
`else
    assign fire = '0;
`endif

endmodule
